instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16, max cycles WAIT holds mem_req without mem_ack before timeout fault.
REQ-002 clock  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 fetch_start  in  1  one-cycle pulse from stage sequencer: begin fetch.
REQ-005 instruction_addr  in  32  fetch address from program counter.
REQ-006 mem_req  out  1  instruction-memory read request.
REQ-007 mem_addr  out  32  read address; valid while mem_req=1.
REQ-008 mem_ack  in  1  memory response valid.
REQ-009 mem_rdata  in  32  read data; sampled only when mem_ack=1.
REQ-010 mem_error  in  1  bus error; qualified by mem_ack.
REQ-011 instruction  out  32  latched instruction word.
REQ-012 fetch_done  out  1  one-cycle pulse: instruction valid.
REQ-013 fetch_busy  out  1  high in every state except IDLE.
REQ-014 fetch_fault  out  1  one-cycle pulse: fetch failed.
REQ-015 fault_cause  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout.

Function
REQ-016 FSM states: IDLE, WAIT, DONE, FAULT.
REQ-017 IDLE, fetch_start=1, instruction_addr[1:0]=00: latch address into mem_addr, clear timeout counter, go WAIT; mem_req=1 from next cycle.
REQ-018 IDLE, fetch_start=1, instruction_addr[1:0]!=00: go FAULT with cause 01; mem_req never asserted.
REQ-019 WAIT: mem_req=1, mem_addr stable until exit.
REQ-020 WAIT, mem_ack=1, mem_error=0: capture mem_rdata into instruction, go DONE.
REQ-021 WAIT, mem_ack=1, mem_error=1: go FAULT with cause 10; mem_rdata discarded.
REQ-022 WAIT, mem_ack=0: counter increments; on reaching TIMEOUT_CYCLES-1 without ack, go FAULT with cause 11 (mem_req high exactly TIMEOUT_CYCLES cycles).
REQ-023 mem_ack and timeout in same cycle: ack wins.
REQ-024 DONE: fetch_done=1 one cycle, fault_cause=00, next state IDLE.
REQ-025 FAULT: fetch_fault=1 one cycle, instruction=NOP (0x00000013), next state IDLE.
REQ-026 fault_cause holds until next fetch_start accepted (then 00).
REQ-027 instruction holds value until next DONE or FAULT.
REQ-028 Latency: fetch_start cycle 0, mem_req cycle 1, ack at cycle k>=1 -> fetch_done at cycle k+1; minimum 2 cycles.
REQ-029 fetch_start outside IDLE ignored; mem_ack outside WAIT ignored.
REQ-030 mem_req deasserts on the cycle after the ack/fault transition; never two consecutive fetches without passing IDLE.

Reset
REQ-031 Reset: state IDLE, mem_req 0, mem_addr BOOT_ADDRESS, instruction 0x00000013, fetch_done 0, fetch_fault 0, fault_cause 00, counter 0, fetch_busy 0.
REQ-032 Reset has priority over all inputs, including fetch_start and mem_ack in the same cycle.
REQ-033 Reset during WAIT drops mem_req next edge; a late mem_ack after reset is ignored.

Structure
REQ-034 Shared definitions package holds word type (32-bit), BOOT_ADDRESS, NOP_INSTRUCTION constant, fault-cause enum and fetch-state enum.
REQ-035 Single module, no sub-modules; timeout counter width $clog2(TIMEOUT_CYCLES)+1.

Verification
REQ-036 Reset, fetch_start addr 0x00000100, mem_ack at cycle 1 with data 0x00500093 -> mem_addr 0x100, fetch_done cycle 2, instruction 0x00500093.
REQ-037 fetch_start addr 0x00000200, ack after 3 wait cycles with data 0xFFF00113 -> mem_req high cycles 1-4, fetch_done cycle 5, mem_addr stable throughout.
REQ-038 fetch_start addr 0x00000102 -> mem_req never high, fetch_fault cycle 1, fault_cause 01, instruction 0x00000013.
REQ-039 fetch_start addr 0x00000300, mem_ack+mem_error at cycle 2 -> fetch_fault cycle 3, fault_cause 10; next good fetch clears cause to 00.
REQ-040 fetch_start, no ack, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, fault_cause 11; fetch_start pulses during WAIT ignored.
REQ-041 reset asserted in WAIT cycle 2, mem_ack pulse at cycle 3 -> IDLE, mem_req 0, no fetch_done, instruction 0x00000013.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: the word type, the boot
// address and NOP encoding, the fault-cause codes and the fetch FSM states.
package instruction_fetch_pkg;

    typedef logic [31:0] word_t;

    localparam word_t BOOT_ADDRESS    = 32'h0000_0000;
    localparam word_t NOP_INSTRUCTION = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_BUS_ERROR  = 2'b10,
        CAUSE_TIMEOUT    = 2'b11
    } fault_cause_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read bus between the fetch unit and instruction memory.
//   mem_req   : read request, held while a fetch is outstanding
//   mem_addr  : read address, valid while mem_req=1
//   mem_ack   : response valid
//   mem_rdata : read data, meaningful only with mem_ack=1
//   mem_error : bus error, qualified by mem_ack
// master = fetch unit, slave = memory.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic  mem_req;
    word_t mem_addr;
    logic  mem_ack;
    word_t mem_rdata;
    logic  mem_error;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        input  mem_error
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        output mem_error
    );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: on a fetch_start pulse issues one read on the
// instruction-memory bus, waits (bounded by TIMEOUT_CYCLES) for the ack and
// reports either a fetched instruction or a fault with its cause.
//
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   fetch_start       : one-cycle pulse, begin a fetch (honoured in IDLE only)
//   instruction_addr  : fetch address from the program counter
//   mem_bus           : instruction-memory read bus (master side)
//   instruction       : latched instruction word (NOP after a fault)
//   fetch_done        : one-cycle pulse, instruction valid
//   fetch_busy        : high whenever the FSM is not in IDLE
//   fetch_fault       : one-cycle pulse, fetch failed
//   fault_cause       : 00 none, 01 misaligned, 10 bus error, 11 timeout
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for fetch_start
// ST_WAIT  | mem_req held high, waiting for mem_ack or timeout
// ST_DONE  | fetch_done pulse, instruction valid
// ST_FAULT | fetch_fault pulse, instruction forced to NOP
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_start,
    input  word_t                instruction_addr,
    instruction_fetch_if.master  mem_bus,
    output word_t                instruction,
    output logic                 fetch_done,
    output logic                 fetch_busy,
    output logic                 fetch_fault,
    output logic [1:0]           fault_cause
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t      state, state_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
    word_t             addr_q, addr_next;
    word_t             instr_q, instr_next;
    fault_cause_t      cause_q, cause_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= BOOT_ADDRESS;
            instr_q  <= NOP_INSTRUCTION;
            cause_q  <= CAUSE_NONE;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            addr_q   <= addr_next;
            instr_q  <= instr_next;
            cause_q  <= cause_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        addr_next     = addr_q;
        instr_next    = instr_q;
        cause_next    = cause_q;

        case (state)
            ST_IDLE: begin
                if (fetch_start) begin
                    if (instruction_addr[1:0] == 2'b00) begin
                        addr_next     = instruction_addr;
                        wait_cnt_next = '0;
                        cause_next    = CAUSE_NONE;
                        state_next    = ST_WAIT;
                    end else begin
                        // Misaligned: fault straight away, the bus is never touched.
                        instr_next = NOP_INSTRUCTION;
                        cause_next = CAUSE_MISALIGNED;
                        state_next = ST_FAULT;
                    end
                end
            end
            ST_WAIT: begin
                // An ack in the final wait cycle still wins over the timeout.
                if (mem_bus.mem_ack) begin
                    if (mem_bus.mem_error) begin
                        instr_next = NOP_INSTRUCTION;
                        cause_next = CAUSE_BUS_ERROR;
                        state_next = ST_FAULT;
                    end else begin
                        instr_next = mem_bus.mem_rdata;
                        state_next = ST_DONE;
                    end
                end else if (wait_cnt == CNT_LAST) begin
                    instr_next = NOP_INSTRUCTION;
                    cause_next = CAUSE_TIMEOUT;
                    state_next = ST_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_FAULT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign mem_bus.mem_req  = (state == ST_WAIT);
    assign mem_bus.mem_addr = addr_q;
    assign instruction      = instr_q;
    assign fault_cause      = cause_q;
    assign fetch_done       = (state == ST_DONE);
    assign fetch_fault      = (state == ST_FAULT);
    assign fetch_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios followed by randomized
// fetches, each judged against an outcome model computed from the fetch rules
// (alignment, ack cycle, error flag, timeout budget).
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int T = 16;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    logic  fetch_start = 1'b0;
    word_t instruction_addr = '0;
    word_t instruction;
    logic  fetch_done, fetch_busy, fetch_fault;
    logic [1:0] fault_cause;

    int checks = 0;
    int errors = 0;

    word_t exp_instr;
    logic [1:0] exp_cause;

    instruction_fetch_if mem_bus ();

    instruction_fetch #(.TIMEOUT_CYCLES(T)) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_start      (fetch_start),
        .instruction_addr (instruction_addr),
        .mem_bus          (mem_bus),
        .instruction      (instruction),
        .fetch_done       (fetch_done),
        .fetch_busy       (fetch_busy),
        .fetch_fault      (fetch_fault),
        .fault_cause      (fault_cause)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // One fetch. ack_cyc is the cycle (fetch_start = cycle 0) in which mem_ack
    // is driven; 0 means never. noise adds fetch_start pulses while waiting.
    task automatic run_fetch(input word_t addr, input int ack_cyc, input bit err,
                             input word_t data, input bit noise);
        int e_end, e_req;
        bit e_done;
        int obs_end, req_cnt;
        bit addr_ok;
        logic o_done, o_fault;
        word_t o_instr;
        logic [1:0] o_cause;

        // Outcome model.
        if (addr[1:0] != 2'b00) begin
            e_end = 1; e_req = 0; e_done = 0;
            exp_cause = 2'b01; exp_instr = NOP_INSTRUCTION;
        end else if (ack_cyc >= 1 && ack_cyc <= T) begin
            e_end = ack_cyc + 1; e_req = ack_cyc;
            if (err) begin
                e_done = 0; exp_cause = 2'b10; exp_instr = NOP_INSTRUCTION;
            end else begin
                e_done = 1; exp_cause = 2'b00; exp_instr = data;
            end
        end else begin
            e_end = T + 1; e_req = T; e_done = 0;
            exp_cause = 2'b11; exp_instr = NOP_INSTRUCTION;
        end

        check("busy_before_start", {31'd0, fetch_busy}, 32'd0);
        fetch_start = 1'b1;
        instruction_addr = addr;
        mem_bus.mem_ack = 1'b0;
        obs_end = 0; req_cnt = 0; addr_ok = 1'b1;
        o_done = 1'b0; o_fault = 1'b0; o_instr = '0; o_cause = '0;

        for (int c = 1; c <= 60; c++) begin
            next_cycle();
            if (mem_bus.mem_req === 1'b1) begin
                req_cnt++;
                if (mem_bus.mem_addr !== addr) addr_ok = 1'b0;
            end
            if (fetch_done === 1'b1 || fetch_fault === 1'b1) begin
                obs_end = c; o_done = fetch_done; o_fault = fetch_fault;
                o_instr = instruction; o_cause = fault_cause;
            end
            fetch_start = (obs_end == 0 && noise) ? 1'($urandom_range(0, 1)) : 1'b0;
            instruction_addr = $urandom;
            mem_bus.mem_ack = (c == ack_cyc);
            mem_bus.mem_error = err;
            mem_bus.mem_rdata = (c == ack_cyc) ? data : $urandom;
            if (obs_end != 0) break;
        end

        check("end_cycle", obs_end, e_end);
        check("done_pulse", {31'd0, o_done}, {31'd0, e_done});
        check("fault_pulse", {31'd0, o_fault}, {31'd0, !e_done});
        check("req_cycles", req_cnt, e_req);
        check("addr_stable", {31'd0, addr_ok}, 32'd1);
        check("instr_at_end", o_instr, exp_instr);
        check("cause_at_end", {30'd0, o_cause}, {30'd0, exp_cause});

        // Back in IDLE: results hold, a stray ack is ignored.
        next_cycle();
        check("idle_busy", {31'd0, fetch_busy}, 32'd0);
        check("idle_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check("idle_pulses", {30'd0, fetch_done, fetch_fault}, 32'd0);
        check("idle_instr_hold", instruction, exp_instr);
        check("idle_cause_hold", {30'd0, fault_cause}, {30'd0, exp_cause});
        fetch_start = 1'b0;
        mem_bus.mem_ack = 1'($urandom_range(0, 1));
        mem_bus.mem_error = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata = $urandom;
        next_cycle();
        check("stray_ack_instr", instruction, exp_instr);
        check("stray_ack_busy", {31'd0, fetch_busy}, 32'd0);
        mem_bus.mem_ack = 1'b0;
    endtask

    initial begin
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_error = 1'b0;
        mem_bus.mem_rdata = '0;

        next_cycle();
        next_cycle();
        reset = 1'b0;
        check("rst_req", {31'd0, mem_bus.mem_req}, 32'd0);
        check("rst_addr", mem_bus.mem_addr, BOOT_ADDRESS);
        check("rst_instr", instruction, NOP_INSTRUCTION);
        check("rst_pulses", {30'd0, fetch_done, fetch_fault}, 32'd0);
        check("rst_cause", {30'd0, fault_cause}, 32'd0);
        check("rst_busy", {31'd0, fetch_busy}, 32'd0);
        exp_instr = NOP_INSTRUCTION;
        exp_cause = 2'b00;

        // Directed scenarios.
        run_fetch(32'h0000_0100, 1, 1'b0, 32'h0050_0093, 1'b0);
        run_fetch(32'h0000_0200, 4, 1'b0, 32'hFFF0_0113, 1'b0);
        run_fetch(32'h0000_0102, 1, 1'b0, 32'h1234_5678, 1'b0);
        run_fetch(32'h0000_0300, 2, 1'b1, 32'hDEAD_BEEF, 1'b0);
        run_fetch(32'h0000_0304, 1, 1'b0, 32'h0000_0537, 1'b0);
        run_fetch(32'h0000_0400, 0, 1'b0, 32'h0, 1'b1);
        run_fetch(32'h0000_0404, T, 1'b0, 32'hCAFE_F00D, 1'b0);
        run_fetch(32'h0000_0408, T + 1, 1'b0, 32'hBAD0_0001, 1'b0);
        run_fetch(32'h0000_040C, 1, 1'b0, 32'h00A0_0513, 1'b0);

        // Reset in WAIT cycle 2, late ack in cycle 3.
        fetch_start = 1'b1;
        instruction_addr = 32'h0000_0500;
        next_cycle();
        fetch_start = 1'b0;
        check("rw_req_c1", {31'd0, mem_bus.mem_req}, 32'd1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_error = 1'b0;
        mem_bus.mem_rdata = 32'h7777_7777;
        check("rw_req_c3", {31'd0, mem_bus.mem_req}, 32'd0);
        check("rw_busy_c3", {31'd0, fetch_busy}, 32'd0);
        check("rw_instr_c3", instruction, NOP_INSTRUCTION);
        next_cycle();
        mem_bus.mem_ack = 1'b0;
        check("rw_done_c4", {31'd0, fetch_done}, 32'd0);
        check("rw_busy_c4", {31'd0, fetch_busy}, 32'd0);
        check("rw_instr_c4", instruction, NOP_INSTRUCTION);
        exp_instr = NOP_INSTRUCTION;
        exp_cause = 2'b00;

        // Reset wins over fetch_start in the same cycle.
        reset = 1'b1;
        fetch_start = 1'b1;
        instruction_addr = 32'h0000_0600;
        next_cycle();
        reset = 1'b0;
        fetch_start = 1'b0;
        check("rp_busy", {31'd0, fetch_busy}, 32'd0);
        check("rp_req", {31'd0, mem_bus.mem_req}, 32'd0);
        next_cycle();
        check("rp_busy2", {31'd0, fetch_busy}, 32'd0);

        // Randomized fetches.
        for (int n = 0; n < 40; n++) begin
            int mode, ack_cyc;
            bit err;
            word_t addr;
            mode = $urandom_range(0, 9);
            addr = {$urandom} & 32'hFFFF_FFFC;
            err = 1'b0;
            if (mode == 0) begin
                addr[1:0] = 2'($urandom_range(1, 3));
                ack_cyc = 1;
            end else if (mode == 1) begin
                ack_cyc = 0;
            end else if (mode == 2) begin
                ack_cyc = T + $urandom_range(1, 3);
            end else begin
                ack_cyc = $urandom_range(1, T);
                err = ($urandom_range(0, 3) == 0);
            end
            run_fetch(addr, ack_cyc, err, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
